// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared constants for the FIR front end: default sample width, default FIFO
// address width and a helper that turns an address width into an entry count.
// -----------------------------------------------------------------------------
package fir_pkg;

    localparam int SAMPLE_W    = 16;
    localparam int FIFO_ADDR_W = 6;

    // Number of entries addressed by an addr_w-bit pointer.
    function automatic int fifo_depth(input int addr_w);
        return 32'sd1 <<< addr_w;
    endfunction

    localparam int FIFO_DEPTH = fifo_depth(FIFO_ADDR_W);

endpackage : fir_pkg

// File: rtl/sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
// Register-array storage for sync_fifo: one synchronous write port and one
// asynchronous (combinational) read port. Contents are never reset.
//
// Ports:
//   clk    in   clock, write on rising edge
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  mem[raddr], combinational
// -----------------------------------------------------------------------------
module sync_fifo_mem
    import fir_pkg::*;
#(
    parameter int DATA_W = SAMPLE_W,
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = fifo_depth(ADDR_W);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Write port: store one sample per accepted write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule : sync_fifo_mem

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock sample FIFO between the sample source and the FIR filter core.
// Tracks occupancy in a count register; full/empty and the watermarks are
// decoded from the post-edge count and held in registers. Overflow/underflow
// are one-cycle pulses for every dropped write/read.
//
// Configuration macro: SYNC_FIFO_FWFT_EN
//   undefined : registered read, rd_data/rd_valid update one cycle after the
//               accepting edge; rd_valid pulses once per accepted read.
//   defined   : first-word fall-through, rd_data shows the head word
//               combinationally and rd_valid = ~empty.
//
// Ports:
//   clk           in   clock, rising edge
//   rstn          in   synchronous active-low reset
//   wr_en/wr_data in   write request and sample
//   rd_en         in   read request (pop)
//   rd_data       out  read sample
//   rd_valid      out  rd_data carries a popped/head sample
//   count         out  occupancy 0..DEPTH
//   full/empty    out  count == DEPTH / count == 0
//   almost_full   out  count >= AFULL_TH
//   almost_empty  out  count <= AEMPTY_TH
//   overflow      out  one-cycle pulse, a write was dropped
//   underflow     out  one-cycle pulse, a read was dropped
// -----------------------------------------------------------------------------
module sync_fifo
    import fir_pkg::*;
#(
    parameter int DATA_W    = SAMPLE_W,
    parameter int ADDR_W    = FIFO_ADDR_W,
    parameter int AFULL_TH  = fifo_depth(ADDR_W) - 32'sd4,
    parameter int AEMPTY_TH = 32'sd4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = fifo_depth(ADDR_W);

    localparam logic [ADDR_W:0]   DEPTH_C  = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]   AFULL_C  = AFULL_TH[ADDR_W:0];
    localparam logic [ADDR_W:0]   AEMPTY_C = AEMPTY_TH[ADDR_W:0];
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1'b1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1'b1);

    // Reject illegal watermark settings at elaboration time.
    generate
        if (!((AEMPTY_TH > 32'sd0) && (AEMPTY_TH < AFULL_TH) && (AFULL_TH <= DEPTH)))
        begin : g_bad_thresholds
            $error("sync_fifo: thresholds must satisfy 0 < AEMPTY_TH < AFULL_TH <= DEPTH");
        end
    endgenerate

    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] rd_ptr_r;
    logic [ADDR_W:0]   count_r;
    logic [ADDR_W:0]   count_nxt_s;
    logic              full_r;
    logic              empty_r;
    logic              afull_r;
    logic              aempty_r;
    logic              overflow_r;
    logic              underflow_r;
    logic              wr_acc_s;
    logic              rd_acc_s;
    logic              mem_we_s;
    logic [DATA_W-1:0] mem_rd_data_s;

    // Acceptance decisions and next occupancy, based on pre-edge flags.
    always_comb begin
        wr_acc_s    = wr_en & ~full_r;
        rd_acc_s    = rd_en & ~empty_r;
        count_nxt_s = count_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Nothing is stored while reset is asserted.
    assign mem_we_s = wr_acc_s & rstn;

    sync_fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (wr_ptr_r),
        .wdata (wr_data),
        .raddr (rd_ptr_r),
        .rdata (mem_rd_data_s)
    );

    // Pointers, occupancy, flags and drop pulses; flags decode the next count
    // so they are valid registers in the cycle after the accepting edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
            afull_r     <= 1'b0;
            aempty_r    <= 1'b1;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r     <= count_nxt_s;
            full_r      <= (count_nxt_s == DEPTH_C);
            empty_r     <= (count_nxt_s == '0);
            afull_r     <= (count_nxt_s >= AFULL_C);
            aempty_r    <= (count_nxt_s <= AEMPTY_C);
            overflow_r  <= wr_en & full_r;
            underflow_r <= rd_en & empty_r;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented directly; rd_en acknowledges it.
    assign rd_data  = mem_rd_data_s;
    assign rd_valid = ~empty_r;
`else
    logic [DATA_W-1:0] rd_data_r;
    logic              rd_valid_r;

    // Registered read: capture the head on an accepted pop, hold otherwise.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
        end else begin
            if (rd_acc_s) begin
                rd_data_r <= mem_rd_data_s;
            end
            rd_valid_r <= rd_acc_s;
        end
    end

    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
`endif

    assign count        = count_r;
    assign full         = full_r;
    assign empty        = empty_r;
    assign almost_full  = afull_r;
    assign almost_empty = aempty_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
// Self-checking bench for sync_fifo with default parameters (16 x 64,
// AFULL_TH=60, AEMPTY_TH=4). A queue holds the samples the bench expects the
// FIFO to contain; each accepted write pushes, each accepted read pops.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

`ifdef SYNC_FIFO_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    logic        clk;
    logic        rstn;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [6:0]  count;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic        overflow;
    logic        underflow;

    int          total;
    int          bad;

    logic [15:0] sb[$];
    int          mcount;
    logic        exp_pop;
    logic [15:0] exp_pop_val;
    logic [15:0] pre_rd_data;
    logic        pre_rd_valid;

    sync_fifo dut (
        .clk          (clk),
        .rstn         (rstn),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle of stimulus; updates the reference queue and count.
    task automatic tick(input logic w, input logic [15:0] wd, input logic r);
        logic wa;
        logic ra;
        wr_en   = w;
        wr_data = wd;
        rd_en   = r;
        wa = w && (mcount != 64);
        ra = r && (mcount != 0);
        pre_rd_data  = rd_data;
        pre_rd_valid = rd_valid;
        exp_pop = ra;
        if (ra) exp_pop_val = sb.pop_front();
        if (wa) sb.push_back(wd);
        mcount = mcount + (wa ? 1 : 0) - (ra ? 1 : 0);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic apply_reset(input int cycles);
        rstn = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
        end
        #1;
        sb.delete();
        mcount = 0;
    endtask

    task automatic test_reset();
        wr_en   = 1'b1;
        wr_data = 16'h5A5A;
        rd_en   = 1'b0;
        apply_reset(2);
        total++; if (count !== 7'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
        total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL reset_aempty got=%b exp=1", almost_empty); end
        total++; if (full !== 1'b0 || almost_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b%b exp=00", full, almost_full); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b exp=00", overflow, underflow); end
        wr_en = 1'b0;
        rstn  = 1'b1;
        tick(1'b0, 16'h0000, 1'b0);
        total++; if (count !== 7'd0 || empty !== 1'b1) begin bad++; $display("FAIL reset_no_write got=%0d/%b exp=0/1", count, empty); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 64; i++) begin
            tick(1'b1, 16'(i), 1'b0);
            if (i == 3 || i == 4) begin
                total++;
                if (almost_empty !== (i == 3)) begin bad++; $display("FAIL fill_aempty_%0d got=%b exp=%b", i + 1, almost_empty, (i == 3)); end
            end
            if (i == 58 || i == 59) begin
                total++;
                if (almost_full !== (i == 59)) begin bad++; $display("FAIL fill_afull_%0d got=%b exp=%b", i + 1, almost_full, (i == 59)); end
            end
            if (i == 62) begin
                total++;
                if (full !== 1'b0) begin bad++; $display("FAIL fill_full_63 got=%b exp=0", full); end
            end
        end
        total++; if (full !== 1'b1 || count !== 7'd64) begin bad++; $display("FAIL fill_full got=%b/%0d exp=1/64", full, count); end
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL fill_empty got=%b exp=0", empty); end
        for (int i = 0; i < 64; i++) begin
            tick(1'b0, 16'h0000, 1'b1);
            total++;
            if ((FWFT ? pre_rd_data : rd_data) !== exp_pop_val || exp_pop_val !== 16'(i))
            begin bad++; $display("FAIL drain_data_%0d got=%h exp=%h", i, (FWFT ? pre_rd_data : rd_data), 16'(i)); end
            total++;
            if ((FWFT ? pre_rd_valid : rd_valid) !== 1'b1) begin bad++; $display("FAIL drain_valid_%0d got=0 exp=1", i); end
            total++;
            if (count !== 7'(63 - i)) begin bad++; $display("FAIL drain_count_%0d got=%0d exp=%0d", i, count, 63 - i); end
        end
        total++; if (empty !== 1'b1 || almost_empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b%b exp=11", empty, almost_empty); end
        tick(1'b0, 16'h0000, 1'b0);
        if (!FWFT) begin
            total++;
            if (rd_valid !== 1'b0 || rd_data !== 16'h003F) begin bad++; $display("FAIL drain_hold got=%b/%h exp=0/003f", rd_valid, rd_data); end
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 64; i++) tick(1'b1, 16'h0100 + 16'(i), 1'b0);
        tick(1'b1, 16'hBEEF, 1'b0);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_pulse got=%b exp=1", overflow); end
        total++; if (count !== 7'd64 || full !== 1'b1) begin bad++; $display("FAIL ovf_count got=%0d/%b exp=64/1", count, full); end
        tick(1'b0, 16'h0000, 1'b0);
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_one_cycle got=%b exp=0", overflow); end
        for (int i = 0; i < 64; i++) begin
            tick(1'b0, 16'h0000, 1'b1);
            total++;
            if ((FWFT ? pre_rd_data : rd_data) !== exp_pop_val || exp_pop_val === 16'hBEEF)
            begin bad++; $display("FAIL ovf_drain_%0d got=%h exp=%h", i, (FWFT ? pre_rd_data : rd_data), exp_pop_val); end
        end
        total++; if (empty !== 1'b1 || sb.size() != 0) begin bad++; $display("FAIL ovf_empty got=%b exp=1", empty); end
    endtask

    task automatic test_underflow_empty_access();
        tick(1'b1, 16'h1234, 1'b1);
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL udf_pulse got=%b exp=1", underflow); end
        total++; if (count !== 7'd1 || empty !== 1'b0) begin bad++; $display("FAIL udf_count got=%0d/%b exp=1/0", count, empty); end
        if (!FWFT) begin
            total++;
            if (rd_valid !== 1'b0) begin bad++; $display("FAIL udf_rd_valid got=%b exp=0", rd_valid); end
        end
        tick(1'b0, 16'h0000, 1'b1);
        total++; if ((FWFT ? pre_rd_data : rd_data) !== 16'h1234) begin bad++; $display("FAIL udf_read got=%h exp=1234", (FWFT ? pre_rd_data : rd_data)); end
        total++; if (underflow !== 1'b0 || count !== 7'd0) begin bad++; $display("FAIL udf_after got=%b/%0d exp=0/0", underflow, count); end
    endtask

    task automatic test_full_simultaneous();
        for (int i = 0; i < 64; i++) tick(1'b1, 16'h0200 + 16'(i), 1'b0);
        tick(1'b1, 16'hAAAA, 1'b1);
        total++; if (count !== 7'd63 || full !== 1'b0) begin bad++; $display("FAIL fsim_count got=%0d/%b exp=63/0", count, full); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL fsim_ovf got=%b exp=1", overflow); end
        total++; if ((FWFT ? pre_rd_data : rd_data) !== 16'h0200) begin bad++; $display("FAIL fsim_head got=%h exp=0200", (FWFT ? pre_rd_data : rd_data)); end
        for (int i = 0; i < 63; i++) begin
            tick(1'b0, 16'h0000, 1'b1);
            total++;
            if ((FWFT ? pre_rd_data : rd_data) !== exp_pop_val || exp_pop_val === 16'hAAAA)
            begin bad++; $display("FAIL fsim_drain_%0d got=%h exp=%h", i, (FWFT ? pre_rd_data : rd_data), exp_pop_val); end
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL fsim_empty got=%b exp=1", empty); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        for (int i = 0; i < 10; i++) tick(1'b1, 16'h3000 + 16'(i), 1'b0);
        for (int i = 0; i < 200; i++) begin
            v = 16'($urandom_range(0, 65535));
            tick(1'b1, v, 1'b1);
            total++;
            if (count !== 7'd10) begin bad++; $display("FAIL b2b_count_%0d got=%0d exp=10", i, count); end
            total++;
            if ((FWFT ? pre_rd_data : rd_data) !== exp_pop_val || (FWFT ? pre_rd_valid : rd_valid) !== 1'b1)
            begin bad++; $display("FAIL b2b_data_%0d got=%h exp=%h", i, (FWFT ? pre_rd_data : rd_data), exp_pop_val); end
        end
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 16'h0000, 1'b1);
            total++;
            if ((FWFT ? pre_rd_data : rd_data) !== exp_pop_val) begin bad++; $display("FAIL b2b_tail_%0d got=%h exp=%h", i, (FWFT ? pre_rd_data : rd_data), exp_pop_val); end
        end
        total++; if (empty !== 1'b1 || count !== 7'd0) begin bad++; $display("FAIL b2b_empty got=%b/%0d exp=1/0", empty, count); end
    endtask

    task automatic test_midop_reset();
        for (int i = 0; i < 5; i++) tick(1'b1, 16'h4000 + 16'(i), 1'b0);
        tick(1'b0, 16'h0000, 1'b1);
        wr_en = 1'b1;
        rd_en = 1'b1;
        apply_reset(1);
        wr_en = 1'b0;
        rd_en = 1'b0;
        total++; if (count !== 7'd0 || empty !== 1'b1 || almost_empty !== 1'b1) begin bad++; $display("FAIL mid_reset_count got=%0d/%b exp=0/1", count, empty); end
        if (!FWFT) begin
            total++;
            if (rd_valid !== 1'b0 || rd_data !== 16'h0000) begin bad++; $display("FAIL mid_reset_rd got=%b/%h exp=0/0000", rd_valid, rd_data); end
        end
        total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL mid_reset_pulses got=%b%b exp=00", overflow, underflow); end
        rstn = 1'b1;
        tick(1'b1, 16'h5555, 1'b0);
        tick(1'b0, 16'h0000, 1'b1);
        total++; if ((FWFT ? pre_rd_data : rd_data) !== 16'h5555) begin bad++; $display("FAIL mid_reset_after got=%h exp=5555", (FWFT ? pre_rd_data : rd_data)); end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        mcount      = 0;
        exp_pop     = 1'b0;
        exp_pop_val = 16'h0000;
        rstn        = 1'b0;
        wr_en       = 1'b0;
        rd_en       = 1'b0;
        wr_data     = 16'h0000;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow_empty_access();
        test_full_simultaneous();
        test_back_to_back();
        test_midop_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sync_fifo

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised sample FIFO that replaces the fixed 64×16 dual-clock buffer ahead of the FIR tap chain. Width, depth and watermark thresholds are parameters. The block accepts a write and a read in the same cycle, and reports occupancy, almost-full/almost-empty watermarks and overflow/underflow events. It sits between the sample source and the filter core, both of which run on one clock.

## Interface
Parameters:
- DATA_W, 16: sample width in bits.
- ADDR_W, 6: address bits; DEPTH = 2**ADDR_W entries (64).
- AFULL_TH, DEPTH-4: almost_full asserts when count >= AFULL_TH.
- AEMPTY_TH, 4: almost_empty asserts when count <= AEMPTY_TH.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rstn  in  1  reset; synchronous, active-low.
- wr_en  in  1  write request.
- wr_data  in  DATA_W  write sample.
- rd_en  in  1  read request (pop).
- rd_data  out  DATA_W  read sample.
- rd_valid  out  1  rd_data carries a popped/head sample.
- count  out  ADDR_W+1  occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- overflow  out  1  one-cycle pulse: a write was dropped.
- underflow  out  1  one-cycle pulse: a read was dropped.

## Operation
- Storage: DEPTH × DATA_W register array. wr_ptr and rd_ptr are ADDR_W bits and wrap modulo DEPTH. The count register tracks occupancy; full and empty are decoded from count, not from pointer compare.
- Accept rules use state registered before the edge:
  - wr_acc = wr_en & ~full.
  - rd_acc = rd_en & ~empty.
- Write accepted: mem[wr_ptr] <= wr_data; wr_ptr +1.
- Read accepted: rd_ptr +1.
- Count: +1 if wr_acc only, −1 if rd_acc only, unchanged if both or neither.
- Simultaneous write and read:
  - both accepted when 0 < count < DEPTH;
  - when full: read accepted, write dropped;
  - when empty: write accepted, read dropped.
- overflow = registered (wr_en & full); underflow = registered (rd_en & empty). Each asserts for one cycle per offending cycle.
- Reset (rstn low at an edge), including mid-operation:
  - pointers, count, rd_data and rd_valid clear to 0;
  - overflow and underflow clear to 0;
  - empty=1, almost_empty=1, full=0, almost_full=0;
  - memory contents are not reset and are discarded.
- Parameter legality: 0 < AEMPTY_TH < AFULL_TH <= DEPTH. Out-of-range values are a compile-time error.

## Timing
- All flags and count reflect the post-edge state, so they change in the cycle after the accepting edge.
- Write-to-read latency (non-FWFT): a sample written at edge N makes empty=0 after edge N, can be popped at edge N+1, and appears on rd_data with rd_valid=1 after edge N+1.
- Non-FWFT read latency is 1 cycle. rd_valid is a 1-cycle pulse per accepted read. rd_data holds its last value when no read is accepted.
- Full throughput: one write and one read per cycle, indefinitely, with count constant.

## Configuration
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word fall-through):
  - rd_data = mem[rd_ptr] combinationally and rd_valid = ~empty;
  - rd_en acknowledges the displayed word, and the next word appears after the edge;
  - zero read latency: a sample written at edge N is visible on rd_data after edge N.
- Undefined: registered read as described under Timing.

## Structure
- Shared package fir_pkg:
  - SAMPLE_W = 16 and FIFO_ADDR_W = 6, used as parameter defaults;
  - localparam helper for DEPTH.
- Sub-module sync_fifo_mem: one write port and one asynchronous read port over the register array. The top keeps pointers, count, flags and the read register.

## Test plan
Defaults used: DATA_W=16, ADDR_W=6, AFULL_TH=60, AEMPTY_TH=4.
- Reset: hold rstn=0 for 2 cycles with wr_en=1 -> count=0, empty=1, almost_empty=1, full=0, rd_valid=0, no write accepted.
- Fill and drain: write 0x0000..0x003F -> almost_full after the 60th write, full=1 and count=64 after the 64th. Read 64 -> data returns in order 0x0000..0x003F, then empty=1.
- Overflow: at full, write 0xBEEF -> overflow pulses 1 cycle, count stays 64, 0xBEEF is never read back.
- Underflow and empty simultaneous access: when empty, assert rd_en+wr_en with 0x1234 -> underflow pulses, count=1. Next read returns 0x1234.
- Full simultaneous access: when full, assert rd_en+wr_en with 0xAAAA -> head is popped, count=63, 0xAAAA is dropped, overflow=1.
- Wrap and throughput: steady read+write each cycle for 200 cycles at count=10 -> count stays 10, pointers wrap, data order is preserved. Repeat with SYNC_FIFO_FWFT_EN defined -> rd_data equals the head with zero latency.
